// File: rtl/jeff_74x181_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : jeff_74x181_nibble_seq
//  Function : Runs a 16-bit 74x181 operation as four LSN-first passes through
//             one external 4-bit slice, rippling carry through the slice.
//  Revision : 1.0  initial release
// ============================================================================
module jeff_74x181_nibble_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op_s,
    input  logic        op_m,
    input  logic        op_ci_bar,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        co_bar_out,
    output logic        aeqb_out,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_ci_bar,
    input  logic [3:0]  alu_f,
    input  logic        alu_co_bar,
    input  logic        alu_aeqb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_idx;
    logic [11:0] r_a_hi;
    logic [11:0] r_b_hi;
    logic [11:0] r_slots;
    logic        r_aeqb_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_idx == 2'd3) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Upper operand nibbles shift down so the next slice input is always [3:0];
    // captured F nibbles shift in from the top so slot 0 lands at [3:0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 16'h0000;
            co_bar_out <= 1'b1;
            aeqb_out   <= 1'b0;
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            alu_s      <= 4'h0;
            alu_m      <= 1'b0;
            alu_ci_bar <= 1'b1;
            r_idx      <= 2'd0;
            r_aeqb_acc <= 1'b1;
            r_a_hi     <= 12'h000;
            r_b_hi     <= 12'h000;
            r_slots    <= 12'h000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy       <= 1'b1;
                        r_idx      <= 2'd0;
                        r_aeqb_acc <= 1'b1;
                        r_a_hi     <= a_in[15:4];
                        r_b_hi     <= b_in[15:4];
                        alu_a      <= a_in[3:0];
                        alu_b      <= b_in[3:0];
                        alu_s      <= op_s;
                        alu_m      <= op_m;
                        alu_ci_bar <= op_ci_bar;
                    end
                end
                S_RUN: begin
                    r_aeqb_acc <= r_aeqb_acc & alu_aeqb;
                    alu_ci_bar <= alu_co_bar;
                    r_idx      <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        result     <= {alu_f, r_slots};
                        co_bar_out <= alu_co_bar;
                        aeqb_out   <= r_aeqb_acc & alu_aeqb;
                        done       <= 1'b1;
                    end else begin
                        r_slots <= {alu_f, r_slots[11:4]};
                        alu_a   <= r_a_hi[3:0];
                        alu_b   <= r_b_hi[3:0];
                        r_a_hi  <= {4'h0, r_a_hi[11:4]};
                        r_b_hi  <= {4'h0, r_b_hi[11:4]};
                    end
                end
                S_DONE: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    r_idx      <= 2'd0;
                    alu_a      <= 4'h0;
                    alu_b      <= 4'h0;
                    alu_s      <= 4'h0;
                    alu_m      <= 1'b0;
                    alu_ci_bar <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jeff_74x181_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jeff_74x181_nibble_seq
//  Function : Bench for the nibble sequencer with a behavioural 74x181 slice.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jeff_74x181_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, op_m, op_ci_bar;
    logic [3:0]  op_s;
    logic [15:0] a_in, b_in;
    logic        busy, done, co_bar_out, aeqb_out;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_ci_bar, alu_co_bar, alu_aeqb;

    always #5 clk = ~clk;

    jeff_74x181_nibble_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_s(op_s), .op_m(op_m),
        .op_ci_bar(op_ci_bar), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .co_bar_out(co_bar_out), .aeqb_out(aeqb_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_ci_bar(alu_ci_bar), .alu_f(alu_f), .alu_co_bar(alu_co_bar),
        .alu_aeqb(alu_aeqb)
    );

    function automatic logic [15:0] logic_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            4'h0: return ~a;        4'h1: return ~(a | b);
            4'h2: return ~a & b;    4'h3: return 16'h0000;
            4'h4: return ~(a & b);  4'h5: return ~b;
            4'h6: return a ^ b;     4'h7: return a & ~b;
            4'h8: return ~a | b;    4'h9: return ~(a ^ b);
            4'hA: return b;         4'hB: return a & b;
            4'hC: return 16'hFFFF;  4'hD: return a | ~b;
            4'hE: return a | b;     default: return a;
        endcase
    endfunction

    // Arithmetic mode is X + Y + carry with the usual 74x181 select decoding.
    function automatic logic [17:0] word_model(input logic [3:0] s, input logic m, input logic ci_bar,
                                               input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, f;
        logic [16:0] sum;
        x   = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        y   = (a & b & {16{s[3]}}) | (a & ~b & {16{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {16'h0000, ~ci_bar};
        f   = m ? logic_fn(s, a, b) : sum[15:0];
        return {(f == 16'hFFFF), ~sum[16], f};
    endfunction

    logic [3:0]  sl_x, sl_y;
    logic [4:0]  sl_sum;
    logic [15:0] sl_lf;
    always_comb begin
        sl_x       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        sl_y       = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
        sl_sum     = {1'b0, sl_x} + {1'b0, sl_y} + {4'h0, ~alu_ci_bar};
        sl_lf      = logic_fn(alu_s, {12'h000, alu_a}, {12'h000, alu_b});
        alu_f      = alu_m ? sl_lf[3:0] : sl_sum[3:0];
        alu_co_bar = ~sl_sum[4];
        alu_aeqb   = (alu_f == 4'hF);
    end

    typedef struct {
        logic [15:0] f;
        logic        co;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] f, input logic co);
        exp_t e;
        e.f = f; e.co = co; e.tag = tag;
        sb.push_back(e);
    endtask

    // Accept, scramble inputs, wait for done, then check latency, result and idle return.
    task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic ci,
                          input logic [15:0] a, input logic [15:0] b, input bit poke,
                          output logic [2:0] ci_tr);
        int   edges;
        int   busy_n;
        exp_t e;
        @(negedge clk);
        op_s = s; op_m = m; op_ci_bar = ci; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = ~a; b_in = b ^ 16'h5A5A; op_s = ~s; op_m = ~m; op_ci_bar = ~ci;
        chk({tag, ".accept"}, {busy, alu_a, alu_b}, {1'b1, a[3:0], b[3:0]});
        busy_n = 1; edges = 0; ci_tr = 3'b000;
        while (!done && edges < 12) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_n++;
            if (edges >= 1 && edges <= 3) ci_tr[edges-1] = alu_ci_bar;
            if (poke) start = (edges == 2);
        end
        start = 1'b0;
        chk({tag, ".latency"}, edges, 4);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            e.f = 16'h0000; e.co = 1'b1; e.tag = tag;
        end else begin
            e = sb.pop_front();
        end
        chk({e.tag, ".result"}, result, e.f);
        chk({e.tag, ".co_bar"}, co_bar_out, e.co);
        chk({e.tag, ".aeqb"}, aeqb_out, (e.f == 16'hFFFF));
        @(posedge clk); #1;
        chk({tag, ".idle"}, {busy, done, alu_a, alu_b, alu_s, alu_m, alu_ci_bar},
            {2'b00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
        chk({tag, ".hold"}, result, e.f);
        chk({tag, ".busy_cycles"}, busy_n, 5);
    endtask

    logic [2:0]  tr;
    logic [3:0]  rs;
    logic        rm, rc;
    logic [15:0] ra, rb;
    logic [17:0] w;
    int          seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; op_s = 4'h0; op_m = 1'b0; op_ci_bar = 1'b1;
        a_in = 16'h0000; b_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", {busy, done, result, co_bar_out, aeqb_out}, {2'b00, 16'h0000, 1'b1, 1'b0});
        chk("rst.alu", {alu_a, alu_b, alu_s, alu_m, alu_ci_bar}, {4'h0, 4'h0, 4'h0, 1'b0, 1'b1});
        @(negedge clk); rst_n = 1'b1;

        push_exp("add", 16'h2233, 1'b1);
        run_op("add", 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 1'b0, tr);

        push_exp("add_ovf", 16'h0000, 1'b0);
        run_op("add_ovf", 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, tr);
        chk("add_ovf.ripple", tr, 3'b000);

        push_exp("sub", 16'h3DCC, 1'b0);
        run_op("sub", 4'b0110, 1'b0, 1'b0, 16'h5000, 16'h1234, 1'b0, tr);

        push_exp("cmp_eq", 16'hFFFF, 1'b1);
        run_op("cmp_eq", 4'b0110, 1'b0, 1'b1, 16'h1357, 16'h1357, 1'b0, tr);
        chk("cmp_eq.aeqb_out", aeqb_out, 1'b1);

        push_exp("cmp_ne", 16'h0000, 1'b0);
        run_op("cmp_ne", 4'b0110, 1'b0, 1'b1, 16'h1357, 16'h1356, 1'b0, tr);
        chk("cmp_ne.aeqb_out", aeqb_out, 1'b0);

        push_exp("xor", 16'hAA55, 1'b0);
        run_op("xor", 4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'h0FF0, 1'b1, tr);

        for (int i = 0; i < 4; i++) begin
            rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
            ra = 16'($urandom); rb = 16'($urandom);
            w  = word_model(rs, rm, rc, ra, rb);
            push_exp("rand", w[15:0], w[16]);
            run_op("rand", rs, rm, rc, ra, rb, 1'b0, tr);
        end

        // Abort an operation two edges after acceptance.
        @(negedge clk);
        op_s = 4'b1001; op_m = 1'b0; op_ci_bar = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort.state", {busy, done, result, co_bar_out, aeqb_out}, {2'b00, 16'h0000, 1'b1, 1'b0});
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort.no_done", seen, 0);

        push_exp("post_abort_add", 16'h0002, 1'b1);
        run_op("post_abort_add", 4'b1001, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, tr);

        chk("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
